rally_ctrl: RTL

RALLY_CTRL -- requirements
Module: rally_ctrl

---
 rtl/rally_ctrl.sv | 74 +++++++
 1 files changed

// File: rtl/rally_ctrl.sv
// rally_ctrl: two-player rally scoring FSM (serve, rally, point pause, game over).
module rally_ctrl #(
  parameter int FLOOR_Y      = 413,
  parameter int MID_X        = 320,
  parameter int WIN_SCORE    = 15,
  parameter int PAUSE_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic       start,
  output logic [4:0] score_left,
  output logic [4:0] score_right,
  output logic       serve_req,
  output logic       serve_side,
  output logic       rally_active,
  output logic       point_pulse,
  output logic       game_over,
  output logic       winner
);
  typedef enum logic [2:0] {IDLE, SERVE, RALLY, PAUSE, OVER} state_t;
  state_t state, state_n;
  logic [26:0] cnt;
  logic land, left_court, win;
  logic [4:0] sl_inc, sr_inc;
  assign land       = (state == RALLY) && frame_tick && (ball_y >= 10'(FLOOR_Y));
  assign left_court = ball_x < 10'(MID_X);
  assign sl_inc     = score_left + 5'd1;
  assign sr_inc     = score_right + 5'd1;
  assign win        = left_court ? (sr_inc == 5'(WIN_SCORE)) : (sl_inc == 5'(WIN_SCORE));
  assign serve_req    = state == SERVE;
  assign rally_active = state == RALLY;
  assign game_over    = state == OVER;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else       state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? SERVE : IDLE;
      SERVE:   state_n = RALLY;
      RALLY:   state_n = land ? (win ? OVER : PAUSE) : RALLY;
      PAUSE:   state_n = (cnt == 27'(PAUSE_CYCLES - 1)) ? SERVE : PAUSE;
      OVER:    state_n = start ? SERVE : OVER;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      score_left  <= '0;
      score_right <= '0;
      serve_side  <= 1'b1;
      winner      <= 1'b0;
      cnt         <= '0;
      point_pulse <= 1'b0;
    end else begin
      point_pulse <= land;
      cnt         <= (state == PAUSE) ? cnt + 27'd1 : '0;
      if (land) begin
        if (left_court) score_right <= sr_inc;
        else            score_left  <= sl_inc;
        serve_side <= left_court;
        if (win) winner <= left_court;
      end
      // new game keeps serve_side so the loser of the final point receives
      if (state == OVER && start) begin
        score_left  <= '0;
        score_right <= '0;
      end
    end
  end
endmodule
